// File: rtl/vga_timing_pkg.sv
// ============================================================================
// Module : vga_timing_pkg
// Brief  : Shared 640x480@60 timing constants, totals helpers, reader state
//          enum and colour-bar table for the VGA pixel reader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    localparam int c_fifo_data_size = 24;

    localparam int c_h_active = 640;
    localparam int c_h_fp     = 16;
    localparam int c_h_sync   = 96;
    localparam int c_h_bp     = 48;

    localparam int c_v_active = 480;
    localparam int c_v_fp     = 10;
    localparam int c_v_sync   = 2;
    localparam int c_v_bp     = 33;

    localparam bit c_sync_pol = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } reader_state_t;

    localparam int c_num_bars = 8;

    // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [c_num_bars-1:0][23:0] c_bar_colours = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

    function automatic int calc_h_total(input int active, input int fp,
                                        input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int calc_v_total(input int active, input int fp,
                                        input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module : vga_timing_gen
// Brief  : Raster h/v counters and stage-0 decodes (de0, hs0, vs0, sof0).
//          With VGA_TEST_PATTERN_EN defined it also exports the colour-bar index.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = c_h_active,
    parameter int H_FP     = c_h_fp,
    parameter int H_SYNC   = c_h_sync,
    parameter int H_BP     = c_h_bp,
    parameter int V_ACTIVE = c_v_active,
    parameter int V_FP     = c_v_fp,
    parameter int V_SYNC   = c_v_sync,
    parameter int V_BP     = c_v_bp
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_enable,
`ifdef VGA_TEST_PATTERN_EN
    output logic [2:0] o_bar_idx,
`endif
    output logic       o_de0,
    output logic       o_hs0,
    output logic       o_vs0,
    output logic       o_sof0
);

    localparam int c_h_total = calc_h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int c_v_total = calc_v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int c_hw      = $clog2(c_h_total);
    localparam int c_vw      = $clog2(c_v_total);

    localparam logic [c_hw-1:0] c_h_last   = c_hw'(c_h_total - 1);
    localparam logic [c_hw-1:0] c_h_act    = c_hw'(H_ACTIVE);
    localparam logic [c_hw-1:0] c_hs_start = c_hw'(H_ACTIVE + H_FP);
    localparam logic [c_hw-1:0] c_hs_end   = c_hw'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [c_vw-1:0] c_v_last   = c_vw'(c_v_total - 1);
    localparam logic [c_vw-1:0] c_v_act    = c_vw'(V_ACTIVE);
    localparam logic [c_vw-1:0] c_vs_start = c_vw'(V_ACTIVE + V_FP);
    localparam logic [c_vw-1:0] c_vs_end   = c_vw'(V_ACTIVE + V_FP + V_SYNC);

    logic [c_hw-1:0] r_h_cnt;
    logic [c_vw-1:0] r_v_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!i_enable) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == c_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == c_v_last) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    assign o_de0  = (r_h_cnt < c_h_act) && (r_v_cnt < c_v_act);
    assign o_hs0  = (r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end);
    assign o_vs0  = (r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end);
    assign o_sof0 = (r_h_cnt == '0) && (r_v_cnt == '0);

`ifdef VGA_TEST_PATTERN_EN
    localparam int c_bar_w = H_ACTIVE / c_num_bars;

    logic [c_hw-1:0] w_bar_q;

    assign w_bar_q   = r_h_cnt / c_hw'(c_bar_w);
    assign o_bar_idx = (w_bar_q >= c_hw'(c_num_bars - 1)) ? 3'd7 : w_bar_q[2:0];
`endif

endmodule

`default_nettype wire

// File: rtl/vga_pixel_reader.sv
// ============================================================================
// Module : vga_pixel_reader
// Brief  : VGA raster generator popping one FIFO word per active pixel, with
//          2-stage registered outputs and sticky underflow. Optional colour
//          bars via VGA_TEST_PATTERN_EN (adds test_mode input).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module vga_pixel_reader
    import vga_timing_pkg::*;
#(
    parameter int FIFO_DATA_SIZE = c_fifo_data_size,
    parameter int H_ACTIVE       = c_h_active,
    parameter int H_FP           = c_h_fp,
    parameter int H_SYNC         = c_h_sync,
    parameter int H_BP           = c_h_bp,
    parameter int V_ACTIVE       = c_v_active,
    parameter int V_FP           = c_v_fp,
    parameter int V_SYNC         = c_v_sync,
    parameter int V_BP           = c_v_bp,
    parameter bit SYNC_POL       = c_sync_pol
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      fifo_empty,
    input  logic [FIFO_DATA_SIZE-1:0] rd_data,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                      test_mode,
`endif
    input  logic                      underflow_clr,
    output logic                      rd_valid,
    output logic                      vga_hs,
    output logic                      vga_vs,
    output logic                      vga_de,
    output logic [FIFO_DATA_SIZE-1:0] vga_rgb,
    output logic                      frame_start,
    output logic                      underflow
);

    reader_state_t r_state;

    logic w_de0, w_hs0, w_vs0, w_sof0;
    logic w_test, w_run, w_pop, w_uflow;
    logic r_s1_de, r_s1_hs, r_s1_vs, r_s1_sof, r_s1_pop;
    logic [FIFO_DATA_SIZE-1:0] w_pix;

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0]                w_bar_idx;
    logic [FIFO_DATA_SIZE-1:0] r_s1_bar;
`endif

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_enable  (enable),
`ifdef VGA_TEST_PATTERN_EN
        .o_bar_idx (w_bar_idx),
`endif
        .o_de0     (w_de0),
        .o_hs0     (w_hs0),
        .o_vs0     (w_vs0),
        .o_sof0    (w_sof0)
    );

`ifdef VGA_TEST_PATTERN_EN
    assign w_test = test_mode;
`else
    assign w_test = 1'b0;
`endif

    // The sof0 pixel that ends SYNC already counts as RUN, so word 0 lands on pixel (0,0).
    assign w_run    = enable & ((r_state == RUN) |
                                ((r_state == SYNC) & w_sof0 & ~fifo_empty));
    assign w_pop    = w_de0 & w_run & ~fifo_empty & ~w_test;
    assign w_uflow  = w_de0 & w_run &  fifo_empty & ~w_test;
    assign rd_valid = w_pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else if (!enable) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    r_state <= SYNC;
                SYNC:    if (w_sof0 && !fifo_empty) r_state <= RUN;
                RUN:     r_state <= RUN;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_bar <= '0;
        end else begin
            r_s1_bar <= (w_test & w_de0 & w_run) ?
                        FIFO_DATA_SIZE'(c_bar_colours[w_bar_idx]) : '0;
        end
    end

    assign w_pix = r_s1_pop ? rd_data : r_s1_bar;
`else
    assign w_pix = r_s1_pop ? rd_data : '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_de     <= 1'b0;
            r_s1_hs     <= 1'b0;
            r_s1_vs     <= 1'b0;
            r_s1_sof    <= 1'b0;
            r_s1_pop    <= 1'b0;
            vga_de      <= 1'b0;
            vga_hs      <= ~SYNC_POL;
            vga_vs      <= ~SYNC_POL;
            vga_rgb     <= '0;
            frame_start <= 1'b0;
        end else begin
            r_s1_de     <= enable & w_de0;
            r_s1_hs     <= enable & w_hs0;
            r_s1_vs     <= enable & w_vs0;
            r_s1_sof    <= w_sof0 & w_run;
            r_s1_pop    <= w_pop;
            vga_de      <= enable & r_s1_de;
            vga_hs      <= r_s1_hs ? SYNC_POL : ~SYNC_POL;
            vga_vs      <= r_s1_vs ? SYNC_POL : ~SYNC_POL;
            vga_rgb     <= enable ? w_pix : '0;
            frame_start <= enable & r_s1_sof;
        end
    end

    // A new starved pixel outranks a clear arriving in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underflow <= 1'b0;
        end else if (w_uflow) begin
            underflow <= 1'b1;
        end else if (underflow_clr) begin
            underflow <= 1'b0;
        end
    end

endmodule

`default_nettype wire
